// File: rtl/packet_stats_pkg.sv
// packet_stats_pkg
//   Shared types and helpers for the packet statistics block.
//   state_t    : packet FSM state (IDLE = no open packet, OPEN = accumulating).
//   max_count(): largest word count representable in cw bits (2^cw - 1).
package packet_stats_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      OPEN = 1'b1
   } state_t;

   function automatic longint unsigned max_count(input int cw);
      return (64'd1 << cw) - 64'd1;
   endfunction

endpackage

// File: rtl/packet_stats_on_first_accumulator.sv
// packet_accumulator
//   Holds the running statistics of the open packet: cnt, sum, max, ovf.
//   Ports:
//     clock, reset          : clock, asynchronous active-high reset
//     load                  : restart the packet with data (cnt=1)
//     acc                   : add data to the packet (ignored when load=1)
//     data                  : incoming word
//     cnt/sum/max_word/ovf  : registered packet statistics
//     add_cnt/add_sum/
//     add_max/add_ovf       : combinational view of the statistics with data
//                             added, used when a word and a close coincide
//   Once cnt reaches its maximum, further words are neither counted, summed
//   nor max-compared; only ovf is set. This bounds the sum so it cannot wrap.
module packet_accumulator
   import packet_stats_pkg::*;
#(
   parameter int width     = 8,
   parameter int cnt_width = 8
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           load,
   input  logic                           acc,
   input  logic [width-1:0]               data,
   output logic [cnt_width-1:0]           cnt,
   output logic [width+cnt_width-1:0]     sum,
   output logic [width-1:0]               max_word,
   output logic                           ovf,
   output logic [cnt_width-1:0]           add_cnt,
   output logic [width+cnt_width-1:0]     add_sum,
   output logic [width-1:0]               add_max,
   output logic                           add_ovf
);

   localparam int SW = width + cnt_width;
   localparam logic [cnt_width-1:0] CNT_MAX = cnt_width'(max_count(cnt_width));

   always_comb begin
      add_cnt = cnt;
      add_sum = sum;
      add_max = max_word;
      add_ovf = ovf;
      if (cnt == CNT_MAX) begin
         add_ovf = 1'b1;
      end else begin
         add_cnt = cnt + cnt_width'(1);
         add_sum = sum + SW'(data);
         if (data > max_word) add_max = data;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt      <= '0;
         sum      <= '0;
         max_word <= '0;
         ovf      <= 1'b0;
      end else if (load) begin
         cnt      <= cnt_width'(1);
         sum      <= SW'(data);
         max_word <= data;
         ovf      <= 1'b0;
      end else if (acc) begin
         cnt      <= add_cnt;
         sum      <= add_sum;
         max_word <= add_max;
         ovf      <= add_ovf;
      end
   end

endmodule

// File: rtl/packet_stats_on_first.sv
// packet_stats_on_first
//   Per-packet statistics (word count, sum, maximum) over a first-marked word
//   stream. A packet closes on the next first word or on flush; each close
//   produces one registered summary beat on down_*.
//   Handshake: up_valid qualifies up_first/up_data in the cycle it is high;
//   there is no backpressure, every valid word is consumed. down_valid is a
//   one-cycle pulse; the down_* fields hold their last values otherwise.
//   Ports:
//     clock, reset      : clock, asynchronous active-high reset
//     up_valid/up_first/up_data : input word stream
//     flush             : close the open packet at the end of this cycle
//     down_valid        : summary pulse
//     down_count/sum/max/overflow : summary of the closed packet
//     orphan_err        : pulse, a non-first word arrived with no open packet
//     debug_state       : current FSM state
module packet_stats_on_first
   import packet_stats_pkg::*;
#(
   parameter int width     = 8,
   parameter int cnt_width = 8
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        up_valid,
   input  logic                        up_first,
   input  logic [width-1:0]            up_data,
   input  logic                        flush,
   output logic                        down_valid,
   output logic [cnt_width-1:0]        down_count,
   output logic [width+cnt_width-1:0]  down_sum,
   output logic [width-1:0]            down_max,
   output logic                        down_overflow,
   output logic                        orphan_err,
   output state_t                      debug_state
);

   localparam int SW = width + cnt_width;

   state_t state_q, state_d;
   // Set when a first word and flush close two packets in one cycle: the
   // accumulator then holds the already-closed single-word packet, which is
   // emitted on the following cycle.
   logic   pend_q, pend_d;

   logic first_word, mid_word;
   logic acc_load, acc_add;
   logic emit, orphan_d;

   logic [cnt_width-1:0] em_cnt;
   logic [SW-1:0]        em_sum;
   logic [width-1:0]     em_max;
   logic                 em_ovf;

   logic [cnt_width-1:0] a_cnt, a_add_cnt;
   logic [SW-1:0]        a_sum, a_add_sum;
   logic [width-1:0]     a_max, a_add_max;
   logic                 a_ovf, a_add_ovf;

   assign first_word  = up_valid & up_first;
   assign mid_word    = up_valid & ~up_first;
   assign debug_state = state_q;

   packet_accumulator #(
      .width     (width),
      .cnt_width (cnt_width)
   ) u_acc (
      .clock    (clock),
      .reset    (reset),
      .load     (acc_load),
      .acc      (acc_add),
      .data     (up_data),
      .cnt      (a_cnt),
      .sum      (a_sum),
      .max_word (a_max),
      .ovf      (a_ovf),
      .add_cnt  (a_add_cnt),
      .add_sum  (a_add_sum),
      .add_max  (a_add_max),
      .add_ovf  (a_add_ovf)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      pend_d   = 1'b0;
      acc_load = first_word;
      acc_add  = 1'b0;
      emit     = 1'b0;
      orphan_d = 1'b0;
      em_cnt   = a_cnt;
      em_sum   = a_sum;
      em_max   = a_max;
      em_ovf   = a_ovf;
      case (state_q)
         IDLE: begin
            if (mid_word) orphan_d = 1'b1;
            if (pend_q) begin
               // The pending packet occupies this cycle's summary slot, so a
               // coincident first+flush must wait one more cycle as well.
               emit = 1'b1;
               if (first_word && flush) pend_d = 1'b1;
            end else if (first_word && flush) begin
               emit   = 1'b1;
               em_cnt = cnt_width'(1);
               em_sum = SW'(up_data);
               em_max = up_data;
               em_ovf = 1'b0;
            end
            if (first_word && !flush) state_d = OPEN;
         end
         OPEN: begin
            if (mid_word) acc_add = 1'b1;
            if (first_word) begin
               emit = 1'b1;
               if (flush) pend_d = 1'b1;
            end else if (flush) begin
               emit = 1'b1;
               if (mid_word) begin
                  // The closing word belongs to this packet.
                  em_cnt = a_add_cnt;
                  em_sum = a_add_sum;
                  em_max = a_add_max;
                  em_ovf = a_add_ovf;
               end
            end
            if (flush) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pend_q        <= 1'b0;
         down_valid    <= 1'b0;
         down_count    <= '0;
         down_sum      <= '0;
         down_max      <= '0;
         down_overflow <= 1'b0;
         orphan_err    <= 1'b0;
      end else begin
         pend_q     <= pend_d;
         down_valid <= emit;
         orphan_err <= orphan_d;
         if (emit) begin
            down_count    <= em_cnt;
            down_sum      <= em_sum;
            down_max      <= em_max;
            down_overflow <= em_ovf;
         end
      end
   end

endmodule

// File: tb/tb_packet_stats_on_first.sv
// Directed bench for packet_stats_on_first. A second instance with
// cnt_width=2 shares the stimulus and is checked for the saturation case.
module tb_packet_stats_on_first;
   import packet_stats_pkg::*;

   logic        clock;
   logic        reset;
   logic        up_valid;
   logic        up_first;
   logic [7:0]  up_data;
   logic        flush;

   logic        down_valid;
   logic [7:0]  down_count;
   logic [15:0] down_sum;
   logic [7:0]  down_max;
   logic        down_overflow;
   logic        orphan_err;
   state_t      debug_state;

   logic        s_valid;
   logic [1:0]  s_count;
   logic [9:0]  s_sum;
   logic [7:0]  s_max;
   logic        s_overflow;
   logic        s_orphan;
   state_t      s_state;

   int compared;
   int mismatched;

   packet_stats_on_first #(.width(8), .cnt_width(8)) dut (
      .clock         (clock),
      .reset         (reset),
      .up_valid      (up_valid),
      .up_first      (up_first),
      .up_data       (up_data),
      .flush         (flush),
      .down_valid    (down_valid),
      .down_count    (down_count),
      .down_sum      (down_sum),
      .down_max      (down_max),
      .down_overflow (down_overflow),
      .orphan_err    (orphan_err),
      .debug_state   (debug_state)
   );

   packet_stats_on_first #(.width(8), .cnt_width(2)) dut_sat (
      .clock         (clock),
      .reset         (reset),
      .up_valid      (up_valid),
      .up_first      (up_first),
      .up_data       (up_data),
      .flush         (flush),
      .down_valid    (s_valid),
      .down_count    (s_count),
      .down_sum      (s_sum),
      .down_max      (s_max),
      .down_overflow (s_overflow),
      .orphan_err    (s_orphan),
      .debug_state   (s_state)
   );

   // clock
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Inputs change on the falling edge; returns at the next falling edge, so
   // outputs then reflect the rising edge that sampled these inputs.
   task automatic drive(input logic v, input logic f, input logic [7:0] d,
                        input logic fl);
      up_valid = v;
      up_first = f;
      up_data  = d;
      flush    = fl;
      @(negedge clock);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_sum(input string tag, input logic [7:0] cnt,
                          input logic [15:0] sum, input logic [7:0] mx,
                          input logic ov);
      chk({tag, ".valid"}, 32'(down_valid), 32'd1);
      chk({tag, ".count"}, 32'(down_count), 32'(cnt));
      chk({tag, ".sum"},   32'(down_sum),   32'(sum));
      chk({tag, ".max"},   32'(down_max),   32'(mx));
      chk({tag, ".ovf"},   32'(down_overflow), 32'(ov));
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      reset    = 1'b1;
      up_valid = 1'b0;
      up_first = 1'b0;
      up_data  = 8'h00;
      flush    = 1'b0;
      repeat (2) @(negedge clock);
      chk("rst.valid",  32'(down_valid), 32'd0);
      chk("rst.count",  32'(down_count), 32'd0);
      chk("rst.sum",    32'(down_sum),   32'd0);
      chk("rst.orphan", 32'(orphan_err), 32'd0);
      chk("rst.state",  32'(debug_state), 32'(IDLE));
      reset = 1'b0;
      @(negedge clock);

      // packet {3,5,2} closed by first word 7
      drive(1, 1, 8'd3, 0);
      chk("p1.open_valid", 32'(down_valid), 32'd0);
      chk("p1.state", 32'(debug_state), 32'(OPEN));
      drive(1, 0, 8'd5, 0);
      drive(1, 0, 8'd2, 0);
      chk("p1.mid_valid", 32'(down_valid), 32'd0);
      drive(1, 1, 8'd7, 0);
      chk_sum("p1", 8'd3, 16'd10, 8'd5, 1'b0);
      drive(0, 0, 8'd0, 0);
      chk("p1.pulse", 32'(down_valid), 32'd0);
      chk("p1.hold",  32'(down_count), 32'd3);

      // back-to-back single-word packets
      drive(1, 1, 8'd9, 0);
      chk_sum("b2b7", 8'd1, 16'd7, 8'd7, 1'b0);
      drive(1, 1, 8'd4, 0);
      chk_sum("b2b9", 8'd1, 16'd9, 8'd9, 1'b0);
      drive(1, 1, 8'd1, 0);
      chk_sum("b2b4", 8'd1, 16'd4, 8'd4, 1'b0);
      drive(0, 0, 8'd0, 1);
      chk_sum("b2b1", 8'd1, 16'd1, 8'd1, 1'b0);
      chk("b2b.state", 32'(debug_state), 32'(IDLE));

      // orphan word
      drive(1, 0, 8'd6, 0);
      chk("orph.err",   32'(orphan_err), 32'd1);
      chk("orph.valid", 32'(down_valid), 32'd0);
      drive(0, 0, 8'd0, 0);
      chk("orph.pulse", 32'(orphan_err), 32'd0);
      chk("orph.state", 32'(debug_state), 32'(IDLE));

      // flush alone
      drive(1, 1, 8'd2, 0);
      drive(1, 0, 8'd8, 0);
      drive(0, 0, 8'd0, 1);
      chk_sum("fl", 8'd2, 16'd10, 8'd8, 1'b0);
      chk("fl.state", 32'(debug_state), 32'(IDLE));
      drive(0, 0, 8'd0, 0);
      chk("fl.pulse", 32'(down_valid), 32'd0);

      // flush with a closing non-first word
      drive(1, 1, 8'd2, 0);
      drive(1, 0, 8'd8, 0);
      drive(1, 0, 8'd1, 1);
      chk_sum("flw", 8'd3, 16'd11, 8'd8, 1'b0);
      chk("flw.state", 32'(debug_state), 32'(IDLE));

      // flush with first word while idle
      drive(1, 1, 8'h55, 1);
      chk_sum("iff", 8'd1, 16'h55, 8'h55, 1'b0);
      chk("iff.state", 32'(debug_state), 32'(IDLE));

      // flush with first word while open: two summaries on consecutive cycles
      drive(1, 1, 8'd3, 0);
      drive(1, 0, 8'd4, 0);
      drive(1, 1, 8'hA0, 1);
      chk_sum("off1", 8'd2, 16'd7, 8'd4, 1'b0);
      chk("off.state", 32'(debug_state), 32'(IDLE));
      drive(0, 0, 8'd0, 0);
      chk_sum("off2", 8'd1, 16'hA0, 8'hA0, 1'b0);
      drive(0, 0, 8'd0, 0);
      chk("off.pulse", 32'(down_valid), 32'd0);

      // saturation: five 0xFF words
      drive(1, 1, 8'hFF, 0);
      repeat (4) drive(1, 0, 8'hFF, 0);
      drive(0, 0, 8'd0, 1);
      chk("sat.valid", 32'(s_valid),    32'd1);
      chk("sat.count", 32'(s_count),    32'd3);
      chk("sat.sum",   32'(s_sum),      32'h2FD);
      chk("sat.max",   32'(s_max),      32'hFF);
      chk("sat.ovf",   32'(s_overflow), 32'd1);
      chk_sum("wide", 8'd5, 16'h4FB, 8'hFF, 1'b0);

      // asynchronous reset mid-packet
      drive(1, 1, 8'h11, 0);
      drive(1, 0, 8'h22, 0);
      up_valid = 1'b0;
      up_first = 1'b0;
      #2 reset = 1'b1;
      #1;
      chk("arst.count", 32'(down_count), 32'd0);
      chk("arst.sum",   32'(down_sum),   32'd0);
      chk("arst.max",   32'(down_max),   32'd0);
      chk("arst.state", 32'(debug_state), 32'(IDLE));
      chk("arst.scount", 32'(s_count), 32'd0);
      @(negedge clock);
      reset = 1'b0;
      drive(0, 0, 8'd0, 0);
      chk("arst.nosum", 32'(down_valid), 32'd0);
      drive(1, 1, 8'd6, 0);
      drive(0, 0, 8'd0, 1);
      chk_sum("arst.next", 8'd1, 16'd6, 8'd6, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
